// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding and prescaler divide-ratio helper for
//               the Hangman round countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    // Timer control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Number of input clocks per timer tick
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running modulo-DIV counter that advances only while
//               enabled; flags the terminal count (DIV-1) combinationally so
//               the owner can register its tick on the same edge the counter
//               wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_pkg::*;
#(
    parameter int DIV = 5
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   TERMINAL = PW'(DIV - 1);
    localparam logic [PW-1:0]   STEP     = PW'(1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          at_terminal;

    assign at_terminal = (presc_q == TERMINAL);
    assign tick_o      = enable_i && at_terminal;

    // Next prescaler value: clear wins, then wrap at terminal, else count up
    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (enable_i) begin
            presc_d = at_terminal ? '0 : (presc_q + STEP);
        end
    end

    // Prescaler register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_countdown_timer.sv
// ============================================================================
// Module      : game_countdown_timer
// Description : Round timer for Hangman. A prescaler turns the system clock
//               into ticks; a loadable down-counter counts those ticks with
//               pause/resume, one-shot or auto-reload expiry, a low-time
//               warning flag and a single-cycle expiry pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 1,
    parameter int CNT_W         = 6,
    parameter int DEFAULT_LIMIT = 32,
    parameter int WARN_LEVEL    = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             auto_reload_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tick_o,
    output logic             running_o,
    output logic             warning_o,
    output logic             expired_o,
    output logic             done_o
);

    localparam int               DIV       = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DEFAULT_LIMIT);
    localparam logic [CNT_W-1:0] WARN_LVL  = CNT_W'(WARN_LEVEL);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] reload_d;
    logic             tick_q;
    logic             tick_d;
    logic             expired_q;
    logic             expired_d;

    logic             presc_clear;
    logic             presc_enable;
    logic             presc_terminal;
    logic [CNT_W-1:0] load_limit;

    // A zero limit would expire immediately, so it selects the default instead
    assign load_limit = (load_value_i == '0) ? DEF_LIMIT : load_value_i;

    // Prescaler only advances in RUN when neither load nor pause overrides it;
    // a pause on the terminal cycle therefore also suppresses that tick.
    assign presc_enable = (state_q == ST_RUN) && !load_i && !pause_i;

    // Fresh period on load, or on start from IDLE/EXPIRED; resume from
    // PAUSED keeps the partial period.
    assign presc_clear  = load_i ||
                          (start_i && ((state_q == ST_IDLE) || (state_q == ST_EXPIRED)));

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (presc_clear),
        .enable_i (presc_enable),
        .tick_o   (presc_terminal)
    );

    // Next-state logic: load > pause > start, countdown on prescaler terminal
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;

        if (load_i) begin
            reload_d = load_limit;
            count_d  = load_limit;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else if (presc_terminal) begin
                        tick_d = 1'b1;
                        // count is always >= 1 in RUN, so this never wraps
                        if (count_q == ONE) begin
                            expired_d = 1'b1;
                            if (auto_reload_i) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    if (start_i) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload limit and registered pulses
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            count_q   <= DEF_LIMIT;
            reload_q  <= DEF_LIMIT;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign tick_o    = tick_q;
    assign expired_o = expired_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_EXPIRED);
    assign warning_o = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) &&
                       (count_q != '0) && (count_q <= WARN_LVL);

endmodule

`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
// ============================================================================
// Module      : tb_game_countdown_timer
// Description : Self-checking bench for game_countdown_timer with DIV=5,
//               CNT_W=6, DEFAULT_LIMIT=32, WARN_LEVEL=5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic       load_i = 1'b0;
    logic [5:0] load_value_i = '0;
    logic       auto_reload_i = 1'b0;
    logic [5:0] count_o;
    logic       tick_o;
    logic       running_o;
    logic       warning_o;
    logic       expired_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    // Observed vector: {count, tick, expired, running, done, warning}
    logic [10:0] obs;
    logic [10:0] sb_q[$];

    assign obs = {count_o, tick_o, expired_o, running_o, done_o, warning_o};

    game_countdown_timer #(
        .CLK_HZ        (5),
        .TICK_HZ       (1),
        .CNT_W         (6),
        .DEFAULT_LIMIT (32),
        .WARN_LEVEL    (5)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start_i),
        .pause_i       (pause_i),
        .load_i        (load_i),
        .load_value_i  (load_value_i),
        .auto_reload_i (auto_reload_i),
        .count_o       (count_o),
        .tick_o        (tick_o),
        .running_o     (running_o),
        .warning_o     (warning_o),
        .expired_o     (expired_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input int cnt, input bit tk, input bit ex,
                                       input bit run, input bit dn, input bit wr);
        return {6'(cnt), tk, ex, run, dn, wr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1;
        sb_q.push_back(mk(32, 0, 0, 0, 0, 0));
        step();
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, e); end
        rst = 1'b0;
        sb_q.push_back(mk(32, 0, 0, 0, 0, 0));
        step();
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, e); end
    endtask

    task automatic test_basic_tick();
        logic [10:0] e;
        start_i = 1'b1;
        sb_q.push_back(mk(32, 0, 0, 1, 0, 0));
        step();
        start_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL basic_start got=%h want=%h", obs, e); end
        for (int k = 1; k <= 11; k++) begin
            sb_q.push_back(mk(32 - k / 5, (k % 5 == 0), 0, 1, 0, 0));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL basic_tick k=%0d got=%h want=%h", k, obs, e); end
        end
    endtask

    task automatic test_oneshot();
        logic [10:0] e;
        load_i = 1'b1; load_value_i = 6'd3; auto_reload_i = 1'b0;
        sb_q.push_back(mk(3, 0, 0, 0, 0, 0));
        step();
        load_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL oneshot_load got=%h want=%h", obs, e); end
        start_i = 1'b1;
        sb_q.push_back(mk(3, 0, 0, 1, 0, 1));
        step();
        start_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL oneshot_start got=%h want=%h", obs, e); end
        for (int k = 1; k <= 22; k++) begin
            if (k < 15)       sb_q.push_back(mk(3 - k / 5, (k % 5 == 0), 0, 1, 0, 1));
            else if (k == 15) sb_q.push_back(mk(0, 1, 1, 0, 1, 0));
            else              sb_q.push_back(mk(0, 0, 0, 0, 1, 0));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL oneshot k=%0d got=%h want=%h", k, obs, e); end
        end
    endtask

    task automatic test_auto_reload();
        logic [10:0] e;
        load_i = 1'b1; load_value_i = 6'd2; auto_reload_i = 1'b1;
        sb_q.push_back(mk(2, 0, 0, 0, 0, 0));
        step();
        load_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reload_load got=%h want=%h", obs, e); end
        start_i = 1'b1;
        sb_q.push_back(mk(2, 0, 0, 1, 0, 1));
        step();
        start_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reload_start got=%h want=%h", obs, e); end
        for (int k = 1; k <= 31; k++) begin
            sb_q.push_back(mk(2 - ((k / 5) % 2), (k % 5 == 0), (k % 10 == 0), 1, 0, 1));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reload k=%0d got=%h want=%h", k, obs, e); end
        end
        auto_reload_i = 1'b0;
    endtask

    task automatic test_pause_resume();
        logic [10:0] e;
        load_i = 1'b1; load_value_i = 6'd6;
        sb_q.push_back(mk(6, 0, 0, 0, 0, 0));
        step();
        load_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL pause_load got=%h want=%h", obs, e); end
        // cycle 0 = start edge, 1..7 run, 8..14 paused, 15 resume, 16..19 run
        for (int c = 0; c <= 19; c++) begin
            start_i = (c == 0) || (c == 15);
            pause_i = (c >= 8) && (c <= 14);
            if (c <= 4)       sb_q.push_back(mk(6, 0, 0, 1, 0, 0));
            else if (c == 5)  sb_q.push_back(mk(5, 1, 0, 1, 0, 1));
            else if (c <= 7)  sb_q.push_back(mk(5, 0, 0, 1, 0, 1));
            else if (c <= 14) sb_q.push_back(mk(5, 0, 0, 0, 0, 1));
            else if (c <= 17) sb_q.push_back(mk(5, 0, 0, 1, 0, 1));
            else if (c == 18) sb_q.push_back(mk(4, 1, 0, 1, 0, 1));
            else              sb_q.push_back(mk(4, 0, 0, 1, 0, 1));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL pause c=%0d got=%h want=%h", c, obs, e); end
        end
        start_i = 1'b0;
        pause_i = 1'b0;
    endtask

    task automatic test_load_priority();
        logic [10:0] e;
        load_i = 1'b1; load_value_i = 6'd0;
        sb_q.push_back(mk(32, 0, 0, 0, 0, 0));
        step();
        load_i = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL load_zero got=%h want=%h", obs, e); end
        load_value_i = 6'd9;
        // cycle 0 start, 5 load on terminal, 6 idle, 7 start, 12 pause on
        // terminal, 13 resume, 14 held terminal fires
        for (int c = 0; c <= 14; c++) begin
            start_i = (c == 0) || (c == 7) || (c == 13);
            load_i  = (c == 5);
            pause_i = (c == 12);
            if (c <= 4)       sb_q.push_back(mk(32, 0, 0, 1, 0, 0));
            else if (c <= 6)  sb_q.push_back(mk(9, 0, 0, 0, 0, 0));
            else if (c <= 11) sb_q.push_back(mk(9, 0, 0, 1, 0, 0));
            else if (c == 12) sb_q.push_back(mk(9, 0, 0, 0, 0, 0));
            else if (c == 13) sb_q.push_back(mk(9, 0, 0, 1, 0, 0));
            else              sb_q.push_back(mk(8, 1, 0, 1, 0, 0));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL loadprio c=%0d got=%h want=%h", c, obs, e); end
        end
        start_i = 1'b0;
        load_i  = 1'b0;
        pause_i = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] e;
        load_i = 1'b1; load_value_i = 6'd11;
        step();
        load_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sb_q.push_back(mk(11 - k / 5, (k % 5 == 0), 0, 1, 0, 0));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL midrun k=%0d got=%h want=%h", k, obs, e); end
        end
        // Asynchronous reset between edges while tick is high
        rst = 1'b1;
        sb_q.push_back(mk(32, 0, 0, 0, 0, 0));
        #2;
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, e); end
        step();
        rst = 1'b0;
        sb_q.push_back(mk(32, 0, 0, 0, 0, 0));
        step();
        e = sb_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL after_reset got=%h want=%h", obs, e); end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sb_q.push_back(mk(32 - k / 5, (k % 5 == 0), 0, 1, 0, 0));
            step();
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL restart k=%0d got=%h want=%h", k, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_tick();
        test_oneshot();
        test_auto_reload();
        test_pause_resume();
        test_load_priority();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
